// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared opcode and state types for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_none  = 4'd0,
        MDU_mult  = 4'd1,
        MDU_multu = 4'd2,
        MDU_div   = 4'd3,
        MDU_divu  = 4'd4,
        MDU_mthi  = 4'd5,
        MDU_mtlo  = 4'd6,
        MDU_mfhi  = 4'd7,
        MDU_mflo  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int DATA_W = 32;

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit holding HI/LO
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        MDUOp,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic [DATA_W-1:0] result
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_op_e          op;
    mdu_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             load, commit, accept;

    logic [DATA_W-1:0] pend_hi, pend_lo;
    logic              pend_wr;
    logic [DATA_W-1:0] calc_hi, calc_lo;
    logic              calc_wr;

    logic [63:0]       prod_s, prod_u;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag, b_mag_nz, b_u_nz;
    logic [DATA_W-1:0] q_mag, r_mag, sq, sr, uq, ur;

    assign op   = mdu_op_e'(MDUOp);
    assign busy = (state == ST_RUN);

    // Products use 64-bit operands so the full product is kept.
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division works on magnitudes so 0x80000000 / -1 cannot overflow:
    // the magnitude quotient is 0x80000000, which is the required wrapped result.
    assign a_neg    = A[31];
    assign b_neg    = B[31];
    assign a_mag    = a_neg ? (~A + 32'd1) : A;
    assign b_mag    = b_neg ? (~B + 32'd1) : B;
    // A zero divisor is replaced by one; the result is discarded at commit anyway.
    assign b_mag_nz = (B == '0) ? 32'd1 : b_mag;
    assign b_u_nz   = (B == '0) ? 32'd1 : B;
    assign q_mag    = a_mag / b_mag_nz;
    assign r_mag    = a_mag % b_mag_nz;
    assign sq       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign sr       = a_neg ? (~r_mag + 32'd1) : r_mag;
    assign uq       = A / b_u_nz;
    assign ur       = A % b_u_nz;

    // Select the pending result for whichever mult/div op is being accepted.
    always_comb begin
        calc_hi = '0;
        calc_lo = '0;
        calc_wr = 1'b0;
        case (op)
            MDU_mult:  begin {calc_hi, calc_lo} = prod_s; calc_wr = 1'b1; end
            MDU_multu: begin {calc_hi, calc_lo} = prod_u; calc_wr = 1'b1; end
            MDU_div:   begin calc_hi = sr; calc_lo = sq; calc_wr = (B != '0); end
            MDU_divu:  begin calc_hi = ur; calc_lo = uq; calc_wr = (B != '0); end
            default:   begin calc_hi = '0; calc_lo = '0; calc_wr = 1'b0; end
        endcase
    end

    // Next-state logic: accept in IDLE, count down in RUN, commit when cnt hits zero.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load    = 1'b0;
        commit  = 1'b0;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = start;
                if (start) begin
                    case (op)
                        MDU_mult, MDU_multu: begin
                            state_d = ST_RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            load    = 1'b1;
                        end
                        MDU_div, MDU_divu: begin
                            state_d = ST_RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            load    = 1'b1;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt == '0) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and countdown register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Pending results captured at accept; HI/LO written by commit or mthi/mtlo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            if (load) begin
                pend_hi <= calc_hi;
                pend_lo <= calc_lo;
                pend_wr <= calc_wr;
            end
            if (commit && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
            if (accept && (op == MDU_mthi)) begin
                HI <= A;
            end
            if (accept && (op == MDU_mtlo)) begin
                LO <= A;
            end
        end
    end

    // Combinational HI/LO read port.
    always_comb begin
        result = '0;
        case (op)
            MDU_mfhi: result = HI;
            MDU_mflo: result = LO;
            default:  result = '0;
        endcase
    end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU. It accepts HI/LO-class operations from the decoder and runs mult/div with a fixed latency. It holds the architectural HI and LO registers and raises `busy` so the hazard unit can stall later HI/LO instructions.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu.
- `clk`  in  1: the single clock. Reset is asynchronous and active-low.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request valid for the operation on `MDUOp` this cycle.
- `MDUOp`  in  4: operation select. Constants `MDU_mult`, `MDU_multu`, `MDU_div`, `MDU_divu`, `MDU_mthi`, `MDU_mtlo`, `MDU_mfhi`, `MDU_mflo`, `MDU_none`.
- `A`  in  32: rs operand.
- `B`  in  32: rt operand.
- `busy`  out  1: a mult/div is in flight.
- `HI`  out  32: architectural HI register.
- `LO`  out  32: architectural LO register.
- `result`  out  32: combinational read. Equals `HI` for `MDU_mfhi`, `LO` for `MDU_mflo`, 0 otherwise.

## Operation
- States: IDLE and RUN. A down-counter `cnt` tracks RUN.
- A request is accepted on a rising edge with `start=1` and `busy=0`.
- Requests arriving while `busy=1` are ignored. The hazard unit guarantees none are issued; the bench asserts this.
- mult/multu: 64-bit product of A and B, signed or unsigned. {HI,LO} = product.
- div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero. The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0): the op still occupies `DIV_CYCLES`, and HI/LO are left unchanged at commit.
- Product, quotient and remainder are computed from A/B at the accepting edge and held in pending registers. Operands may change after that edge.
- mthi/mtlo: HI or LO = A at the accepting edge, with no busy period. `mfhi`, `mflo` and `MDU_none` never change state.
- Unknown `MDUOp` codes behave as `MDU_none`.

## Timing
- Reset (async assert): `busy`=0, `HI`=0, `LO`=0, `cnt`=0, state IDLE, pending discarded.
- An op in flight when reset asserts is lost with no commit.
- After reset deasserts, the first rising edge may accept a request.
- mult/div accepted at edge t0:
  - `busy`=1 from after t0 through the edge t0+N, where N is `MULT_CYCLES` or `DIV_CYCLES`.
  - HI/LO commit at edge t0+N, and `busy` falls after that same edge. `busy` is therefore high for exactly N cycles.
- A new request can be accepted at edge t0+N+1 at the earliest.
  - At edge t0+N `busy` is still 1, so a request presented then is ignored.
- mthi/mtlo accepted at edge t0: the register updates at t0 and `busy` stays 0.
- `result` is combinational from the current HI/LO. A mfhi issued after a commit edge reads the new value.
- The stall condition is owned by the hazard unit: (`busy` | `start` for mult/div) while a HI/LO-class instruction is in D. It is not generated here.

## Structure
- `MDU_*` opcode constants go in the shared `def.v`, next to the `ALU_*` constants.
- No sub-module is needed. The block is a single file: a counter FSM, pending registers, the HI/LO registers and the read mux.
- The datapath uses Verilog `*`, `/` and `%` on 64/32-bit operands, with `$signed` for the signed ops.

## Test plan
- mult: A=0xFFFFFFFF, B=2, start → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=1, LO=0xFFFFFFFE.
- div: A=-7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- Divide by zero: set HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0 → `busy` high 10 cycles, HI=0x11, LO=0x22 unchanged.
- Back-to-back requests:
  - mult accepted, then `start`=1 with mtlo A=0x55 at edges t0+1..t0+5 → all ignored, LO holds the mult result.
  - mtlo presented at t0+6 → accepted, LO=0x55.
- Reset mid-op: pull `reset` low 3 cycles into a div → `busy`, HI, LO all 0 immediately. After release, no commit occurs.
- mthi A=0xDEADBEEF, then next cycle `MDUOp`=MDU_mfhi → `result`=0xDEADBEEF with `busy` never asserted.
